// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response and memory-side signals of the load/store unit.
interface load_store_unit_if;
    logic        start;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        addr_error;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [31:0] data_readdata;
    modport slave (
        input  start, op, addr, wdata, data_readdata,
        output busy, done, rdata, addr_error, data_address, data_read, data_write, data_writedata
    );
    modport master (
        output start, op, addr, wdata, data_readdata,
        input  busy, done, rdata, addr_error, data_address, data_read, data_write, data_writedata
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: big-endian byte/half/word loads and stores, with LWL/LWR and read-modify-write for SB/SH.
module load_store_unit (
    input logic clk,
    input logic reset,
    load_store_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
    state_t state, state_n;
    logic [3:0]  op_q;
    logic [31:0] addr_q, wdata_q, mem_q, rdata_q;
    logic        done_q, addr_error_q, legal, aligned;
    logic [1:0]  off;
    logic [31:0] byte_w, half_w, lwl_w, lwr_w, load_val, mask, rep, merged;
    assign off = addr_q[1:0];
    always_comb begin
        legal   = bus.op <= 4'd6 || (bus.op >= 4'd8 && bus.op <= 4'd10);
        aligned = !((bus.op == 4'd2 || bus.op == 4'd3 || bus.op == 4'd9) && bus.addr[0]) &&
                  !((bus.op == 4'd4 || bus.op == 4'd10) && |bus.addr[1:0]);
    end
    always_comb begin
        state_n = state == IDLE  ? (bus.start && legal && aligned ? (bus.op == 4'd10 ? WRITE : READ) : IDLE)
                : state == READ  ? (op_q[3] ? WRITE : FINISH)
                : state == WRITE ? FINISH : IDLE;
        bus.busy       = state != IDLE;
        bus.data_read  = state == READ;
        bus.data_write = state == WRITE;
    end
    // Load path: shift the addressed lane down (or up for LWL) and fill from rt where needed.
    always_comb begin
        byte_w   = bus.data_readdata >> {~off, 3'b000};
        half_w   = off[1] ? bus.data_readdata : bus.data_readdata >> 16;
        lwl_w    = (bus.data_readdata << {off, 3'b000}) | (wdata_q & ~(32'hFFFF_FFFF << {off, 3'b000}));
        lwr_w    = (bus.data_readdata >> {~off, 3'b000}) | (wdata_q & ~(32'hFFFF_FFFF >> {~off, 3'b000}));
        load_val = op_q == 4'd0 ? {{24{byte_w[7]}}, byte_w[7:0]}
                 : op_q == 4'd1 ? {24'h0, byte_w[7:0]}
                 : op_q == 4'd2 ? {{16{half_w[15]}}, half_w[15:0]}
                 : op_q == 4'd3 ? {16'h0, half_w[15:0]}
                 : op_q == 4'd5 ? lwl_w
                 : op_q == 4'd6 ? lwr_w : bus.data_readdata;
    end
    // Store path: merge the replicated store lane into the previously read word.
    always_comb begin
        mask   = op_q == 4'd8 ? 32'hFF00_0000 >> {off, 3'b000} : (off[1] ? 32'h0000_FFFF : 32'hFFFF_0000);
        rep    = op_q == 4'd8 ? {4{wdata_q[7:0]}} : {2{wdata_q[15:0]}};
        merged = (mem_q & ~mask) | (rep & mask);
        bus.data_writedata = op_q == 4'd10 ? wdata_q : merged;
    end
    assign bus.data_address = {addr_q[31:2], 2'b00};
    assign bus.rdata        = rdata_q;
    assign bus.done         = done_q;
    assign bus.addr_error   = addr_error_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= 4'h0;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            mem_q        <= 32'h0;
            rdata_q      <= 32'h0;
            done_q       <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            state        <= state_n;
            done_q       <= (state == READ && !op_q[3]) || state == WRITE;
            addr_error_q <= state == IDLE && bus.start && !(legal && aligned);
            if (state == IDLE && bus.start) begin
                op_q    <= bus.op;
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
            end
            if (state == READ) begin
                mem_q <= bus.data_readdata;
                if (!op_q[3]) rdata_q <= load_val;
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table vectors, randomized ops against a byte-level model, and reset/back-to-back sequences.
module tb_load_store_unit;
    logic clk = 1'b0;
    logic reset;
    load_store_unit_if bus();
    load_store_unit dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    logic [31:0] mem [256] = '{default: 32'h0};
    logic        pre_en = 1'b0;
    logic [7:0]  pre_idx = 8'h0;
    logic [31:0] pre_val = 32'h0;
    // Memory responds on the falling edge, as the unit expects.
    always @(negedge clk) begin
        if (pre_en) mem[pre_idx] = pre_val;
        bus.data_readdata = mem[bus.data_address[9:2]];
        if (bus.data_write) mem[bus.data_address[9:2]] = bus.data_writedata;
    end

    int vectors = 0, miscompares = 0;
    logic [31:0] model_rdata = 32'h0;
    logic [3:0]  cur_op;
    logic [31:0] cur_addr;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr, wdata, memw, exp_rdata, exp_mem;
        logic        exp_err;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s op=%0d addr=%h: got %h expected %h", name, cur_op, cur_addr, act, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int k);
        return w[31 - 8 * k -: 8];
    endfunction

    function automatic logic model_ok(input logic [3:0] op, input logic [31:0] a);
        if (!(op <= 4'd6 || op == 4'd8 || op == 4'd9 || op == 4'd10)) return 1'b0;
        if ((op == 4'd2 || op == 4'd3 || op == 4'd9) && a[0]) return 1'b0;
        if ((op == 4'd4 || op == 4'd10) && a[1:0] != 2'b00) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op, input int k, input logic [31:0] m, input logic [31:0] rt);
        logic [7:0]  r [4];
        logic [7:0]  b;
        logic [15:0] h;
        b = byte_of(m, k);
        h = {byte_of(m, k & 2), byte_of(m, (k & 2) + 1)};
        case (op)
            4'd0: return {{24{b[7]}}, b};
            4'd1: return {24'h0, b};
            4'd2: return {{16{h[15]}}, h};
            4'd3: return {16'h0, h};
            4'd5: for (int i = 0; i < 4; i++) r[i] = (i + k <= 3) ? byte_of(m, i + k) : byte_of(rt, i);
            4'd6: for (int i = 0; i < 4; i++) r[i] = (i >= 3 - k) ? byte_of(m, i - 3 + k) : byte_of(rt, i);
            default: return m;
        endcase
        return {r[0], r[1], r[2], r[3]};
    endfunction

    function automatic logic [31:0] model_store(input logic [3:0] op, input int k, input logic [31:0] m, input logic [31:0] wd);
        logic [31:0] res;
        res = m;
        if (op == 4'd8) res[31 - 8 * k -: 8] = wd[7:0];
        if (op == 4'd9) res[31 - 8 * (k & 2) -: 16] = wd[15:0];
        if (op == 4'd10) res = wd;
        return res;
    endfunction

    task automatic preload(input logic [31:0] a, input logic [31:0] w);
        #1;
        pre_idx = a[9:2];
        pre_val = w;
        pre_en  = 1'b1;
        @(negedge clk);
        #1 pre_en = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd,
                          output int done_c, output int err_c, output int nr, output int nw,
                          output int ovl, output int busy1, output int bad);
        done_c = 0; err_c = 0; nr = 0; nw = 0; ovl = 0; busy1 = 0; bad = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.addr = a; bus.wdata = wd;
        @(negedge clk);
        bus.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (bus.done && done_c == 0) done_c = c;
            if (bus.addr_error && err_c == 0) err_c = c;
            nr += int'(bus.data_read);
            nw += int'(bus.data_write);
            if (bus.data_read && bus.data_write) ovl = 1;
            if (c == 1) busy1 = int'(bus.busy);
            if ((bus.data_read || bus.data_write) && bus.data_address != {a[31:2], 2'b00}) bad = 1;
            if (c < 6) @(negedge clk);
        end
    endtask

    task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] memw,
                         input logic [31:0] exp_rdata, input logic [31:0] exp_mem, input logic exp_err);
        int done_c, err_c, nr, nw, ovl, busy1, bad;
        logic ok;
        ok = !exp_err;
        cur_op = op; cur_addr = a;
        preload(a, memw);
        run_op(op, a, wd, done_c, err_c, nr, nw, ovl, busy1, bad);
        check("done_cycle", done_c, ok ? ((op == 4'd8 || op == 4'd9) ? 3 : 2) : 0);
        check("err_cycle", err_c, ok ? 0 : 1);
        check("read_count", nr, (ok && op != 4'd10) ? 1 : 0);
        check("write_count", nw, (ok && op >= 4'd8) ? 1 : 0);
        check("rd_wr_overlap", ovl, 0);
        check("busy", busy1, ok ? 1 : 0);
        check("bus_address", bad, 0);
        if (ok && op <= 4'd6) model_rdata = exp_rdata;
        check("rdata", bus.rdata, model_rdata);
        check("mem_word", mem[a[9:2]], exp_mem);
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rw, rm;
        logic [3:0]  ops [13] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd7, 4'd11, 4'd15};
        int ev_write, ev_done;
        tbl[0]  = '{4'd4,  32'h100, 32'h0,        32'h11223344, 32'h11223344, 32'h11223344, 1'b0};
        tbl[1]  = '{4'd0,  32'h103, 32'h0,        32'h11223344, 32'h00000044, 32'h11223344, 1'b0};
        tbl[2]  = '{4'd0,  32'h100, 32'h0,        32'h80FF0000, 32'hFFFFFF80, 32'h80FF0000, 1'b0};
        tbl[3]  = '{4'd3,  32'h102, 32'h0,        32'h80FF0000, 32'h00000000, 32'h80FF0000, 1'b0};
        tbl[4]  = '{4'd8,  32'h201, 32'h00000077, 32'hAABBCCDD, 32'h0,        32'hAA77CCDD, 1'b0};
        tbl[5]  = '{4'd9,  32'h202, 32'h00001234, 32'hAABBCCDD, 32'h0,        32'hAABB1234, 1'b0};
        tbl[6]  = '{4'd4,  32'h102, 32'h0,        32'h11223344, 32'h0,        32'h11223344, 1'b1};
        tbl[7]  = '{4'd9,  32'h201, 32'h00001234, 32'hAABBCCDD, 32'h0,        32'hAABBCCDD, 1'b1};
        tbl[8]  = '{4'd15, 32'h100, 32'h0,        32'h11223344, 32'h0,        32'h11223344, 1'b1};
        tbl[9]  = '{4'd5,  32'h101, 32'hAABBCCDD, 32'h11223344, 32'h223344DD, 32'h11223344, 1'b0};
        tbl[10] = '{4'd6,  32'h101, 32'hAABBCCDD, 32'h11223344, 32'hAABB1122, 32'h11223344, 1'b0};
        tbl[11] = '{4'd10, 32'h300, 32'hDEADBEEF, 32'h00000000, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[12] = '{4'd2,  32'h102, 32'h0,        32'h1234F00D, 32'hFFFFF00D, 32'h1234F00D, 1'b0};
        tbl[13] = '{4'd7,  32'h100, 32'h0,        32'h11223344, 32'h0,        32'h11223344, 1'b1};
        bus.start = 1'b0; bus.op = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0; bus.data_readdata = 32'h0;
        cur_op = 4'h0; cur_addr = 32'h0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_addr_error", bus.addr_error, 0);
        check("reset_rdata", bus.rdata, 0);
        check("reset_data_address", bus.data_address, 0);
        check("reset_writedata", bus.data_writedata, 0);
        check("reset_rd_wr", {bus.data_read, bus.data_write}, 0);
        reset = 1'b0;

        foreach (tbl[i]) apply(tbl[i].op, tbl[i].addr, tbl[i].wdata, tbl[i].memw, tbl[i].exp_rdata, tbl[i].exp_mem, tbl[i].exp_err);

        for (int n = 0; n < 150; n++) begin
            rop = ops[$urandom_range(0, 12)];
            ra  = 32'($urandom_range(0, 1023));
            rw  = $urandom;
            rm  = $urandom;
            apply(rop, ra, rw, rm, model_load(rop, int'(ra[1:0]), rm, rw),
                  (model_ok(rop, ra) && rop >= 4'd8) ? model_store(rop, int'(ra[1:0]), rm, rw) : rm,
                  !model_ok(rop, ra));
        end

        // Start held high: the request arriving in FINISH is ignored, one IDLE cycle separates requests.
        cur_op = 4'd4; cur_addr = 32'h100;
        preload(32'h100, 32'h11223344);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd4; bus.addr = 32'h100; bus.wdata = 32'h0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("b2b_busy_c%0d", c), bus.busy, (c == 3) ? 0 : 1);
            check($sformatf("b2b_done_c%0d", c), bus.done, (c == 2) ? 1 : 0);
        end
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        model_rdata = 32'h11223344;
        check("b2b_rdata", bus.rdata, model_rdata);

        // Reset in the READ cycle of an SB aborts it without any write.
        cur_op = 4'd8; cur_addr = 32'h201;
        preload(32'h201, 32'hAABBCCDD);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 4'd8; bus.addr = 32'h201; bus.wdata = 32'h77;
        @(negedge clk);
        bus.start = 1'b0;
        check("abort_in_read", bus.data_read, 1);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_rd_wr", {bus.data_read, bus.data_write}, 0);
        @(negedge clk);
        reset = 1'b0;
        ev_write = 0; ev_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            ev_write += int'(bus.data_write);
            ev_done  += int'(bus.done);
        end
        check("abort_writes", ev_write, 0);
        check("abort_done", ev_done, 0);
        check("abort_mem", mem[8'h80], 32'hAABBCCDD);
        model_rdata = 32'h0;
        check("abort_rdata", bus.rdata, model_rdata);
        apply(4'd4, 32'h200, 32'h0, 32'hAABBCCDD, 32'hAABBCCDD, 32'hAABBCCDD, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameters: none; the unit SHALL be big-endian, with byte offset 0 at bits 31:24.
REQ-002 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  request strobe, sampled in IDLE only.
REQ-005 op  in  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 LWL, 6 LWR, 8 SB, 9 SH, 10 SW; all other codes are illegal.
REQ-006 addr  in  32  byte address.
REQ-007 wdata  in  32  store data (rt), and the old rt value for LWL/LWR.
REQ-008 busy  out  1  high in any state except IDLE.
REQ-009 done  out  1  one-cycle pulse on completion.
REQ-010 rdata  out  32  load result, held until the next load completes.
REQ-011 addr_error  out  1  one-cycle pulse on misaligned access or illegal op.
REQ-012 data_address  out  32  to memory: {addr_q[31:2],2'b00}.
REQ-013 data_read  out  1  memory read strobe.
REQ-014 data_write  out  1  memory write strobe.
REQ-015 data_writedata  out  32  full word to write.
REQ-016 data_readdata  in  32  memory word; valid before the posedge that ends the cycle in which data_read is high (memory updates on negedge).

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, READ, WRITE, FINISH.
REQ-018 IDLE + start SHALL capture op/addr/wdata into op_q/addr_q/wdata_q; start while busy SHALL be ignored.
REQ-019 Alignment check at start: LH/LHU/SH SHALL need addr[0]=0; LW/SW SHALL need addr[1:0]=0; LB/LBU/SB/LWL/LWR SHALL be unchecked.
REQ-020 A misaligned access or illegal op at start SHALL pulse addr_error the next cycle, stay in IDLE, issue no memory access and produce no done.
REQ-021 Loads and SB/SH transitions: IDLE -> READ; READ SHALL assert data_read for exactly one cycle and capture data_readdata at its closing posedge.
REQ-022 Load flow: READ -> FINISH; rdata SHALL be updated on the READ->FINISH edge; done=1 in FINISH; FINISH -> IDLE.
REQ-023 SW flow: IDLE -> WRITE -> FINISH -> IDLE, with data_writedata=wdata_q.
REQ-024 SB/SH flow: IDLE -> READ -> WRITE -> FINISH -> IDLE; the WRITE word SHALL be the read word with only the addressed byte/halfword replaced by wdata_q[7:0]/[15:0].
REQ-025 WRITE SHALL assert data_write for exactly one cycle; data_read and data_write SHALL never be high together.
REQ-026 Latency from the start cycle to done: LW/LB/LH/LWL/LWR = 2 cycles, SW = 2 cycles, SB/SH = 3 cycles.
REQ-027 Byte select: offset k selects bits [31-8k:24-8k]; halfword offset 0 selects [31:16], offset 2 selects [15:0].
REQ-028 LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend to 32 bits.
REQ-029 LWL, for offset 0/1/2/3: mem / {mem[23:0],rt[7:0]} / {mem[15:0],rt[15:0]} / {mem[7:0],rt[23:0]}.
REQ-030 LWR, for offset 0/1/2/3: {rt[31:8],mem[31:24]} / {rt[31:16],mem[31:16]} / {rt[31:24],mem[31:8]} / mem.
REQ-031 data_read, data_write and busy SHALL be decoded from state only; done and addr_error SHALL be registered.
REQ-032 Outputs SHALL NOT change for a start that arrives in FINISH; the unit SHALL return to IDLE first, so back-to-back requests are spaced by at least one IDLE cycle.

Reset
REQ-033 reset SHALL asynchronously force IDLE; busy, done, addr_error, data_read and data_write SHALL go to 0, and rdata, data_address, data_writedata and the captured registers to 32'h0.
REQ-034 A reset asserted during READ or WRITE SHALL abort immediately, with no write completing after reset assertion and no done pulse.

Verification
REQ-035 Memory word 0x100 = 32'h11223344; LW addr=0x100 -> data_read high 1 cycle, done at cycle +2, rdata=32'h11223344.
REQ-036 Same word; LB addr=0x103 -> rdata=32'h00000044; LB addr=0x100 with word 32'h80FF0000 -> rdata=32'hFFFFFF80; LHU addr=0x102 -> 32'h00000000.
REQ-037 Word 0x200 = 32'hAABBCCDD; SB addr=0x201 wdata=32'h00000077 -> exactly one write of 32'hAA77CCDD at 0x200, done at cycle +3; SH addr=0x202 wdata=32'h1234 -> 32'hAABB1234.
REQ-038 LW addr=0x102 -> addr_error pulse, no data_read/data_write, no done; SH addr=0x201 -> same; op=4'hF -> same.
REQ-039 Word 32'h11223344, rt=32'hAABBCCDD: LWL addr offset 1 -> 32'h223344DD; LWR offset 1 -> 32'hAABB1122.
REQ-040 Assert reset mid-READ of SB -> data_write never asserted, busy=0 immediately, memory unchanged, a following LW completes normally.
